// File: rtl/sd_sector_server_if.sv
// Initiator-side sector buffer port and backing-store port of the
// SD sector server, bundled so both ends share one declaration.
interface sd_sector_server_if #(
   parameter int LBA_W = 8,
   parameter int NDRV  = 3
) ();
   logic [31:0]          sd_lba;
   logic [NDRV-1:0]      sd_rd;
   logic [NDRV-1:0]      sd_wr;
   logic                 sd_ack;
   logic [8:0]           sd_buff_addr;
   logic [7:0]           sd_buff_dout;
   logic                 sd_buff_wr;
   logic [7:0]           sd_buff_din;
   logic [LBA_W+10:0]    mem_addr;
   logic                 mem_rd;
   logic                 mem_wr;
   logic [7:0]           mem_din;
   logic [7:0]           mem_dout;
   logic                 mem_ready;

   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
      input  mem_addr, mem_rd, mem_wr, mem_din
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
      output mem_addr, mem_rd, mem_wr, mem_din
   );
endinterface

// File: rtl/sd_sector_server.sv
// Serves 512-byte sector reads/writes for several virtual drives,
// copying bytes between the initiator buffer and a byte-wide store.
module sd_sector_server #(
   parameter int LBA_W = 8,
   parameter int NDRV  = 3
) (
   input  logic              clk_sys,
   input  logic              areset,
   sd_sector_server_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, ACK, RD_REQ, RD_PUT, WR_ADDR, WR_LAT, WR_REQ, DONE
   } state_t;

   state_t            r_state;
   logic [1:0]        r_drv;
   logic [LBA_W-1:0]  r_lba;
   logic              r_is_rd;
   logic              r_oor;
   logic [8:0]        r_cnt;
   logic              r_ack;
   logic              r_buff_wr;
   logic [8:0]        r_buff_addr;
   logic [7:0]        r_buff_dout;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [7:0]        r_mem_din;
   logic [LBA_W+10:0] r_mem_addr;

   logic [NDRV-1:0]   w_req;
   logic [31:0]       w_sel;
   logic              w_sel_rd;
   logic              w_lba_oor;
   logic              w_last;
   logic [8:0]        w_cnt_nx;

   assign w_req     = bus.sd_rd | bus.sd_wr;
   assign w_lba_oor = (bus.sd_lba >> LBA_W) != 32'd0;
   assign w_last    = r_cnt == 9'd511;
   assign w_cnt_nx  = r_cnt + 9'd1;

   // Descending scan so the lowest requesting drive wins.
   always_comb begin
      w_sel    = '0;
      w_sel_rd = 1'b0;
      for (int i = NDRV - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_sel    = 32'(i);
            w_sel_rd = bus.sd_rd[i];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (areset) begin
         r_state     <= IDLE;
         r_drv       <= '0;
         r_lba       <= '0;
         r_is_rd     <= 1'b0;
         r_oor       <= 1'b0;
         r_cnt       <= '0;
         r_ack       <= 1'b0;
         r_buff_wr   <= 1'b0;
         r_buff_addr <= '0;
         r_buff_dout <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_din   <= '0;
         r_mem_addr  <= '0;
      end else begin
         r_buff_wr <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (|w_req) begin
                  r_drv   <= w_sel[1:0];
                  r_lba   <= bus.sd_lba[LBA_W-1:0];
                  r_is_rd <= w_sel_rd;
                  r_oor   <= w_lba_oor || (w_sel > 32'd3);
                  r_ack   <= 1'b1;
                  r_state <= ACK;
               end
            end
            ACK: begin
               r_cnt <= '0;
               if (r_is_rd) begin
                  r_mem_rd   <= !r_oor;
                  r_mem_addr <= {r_drv, r_lba, 9'd0};
                  r_state    <= RD_REQ;
               end else begin
                  r_buff_addr <= '0;
                  r_state     <= WR_ADDR;
               end
            end
            RD_REQ: begin
               // Out-of-range sectors read as zeros with no store access.
               if (r_oor || bus.mem_ready) begin
                  r_mem_rd    <= 1'b0;
                  r_buff_dout <= r_oor ? 8'h00 : bus.mem_dout;
                  r_buff_wr   <= 1'b1;
                  r_buff_addr <= r_cnt;
                  r_state     <= RD_PUT;
               end
            end
            RD_PUT: begin
               if (w_last) begin
                  r_ack   <= 1'b0;
                  r_state <= DONE;
               end else begin
                  r_cnt      <= w_cnt_nx;
                  r_mem_rd   <= !r_oor;
                  r_mem_addr <= {r_drv, r_lba, w_cnt_nx};
                  r_state    <= RD_REQ;
               end
            end
            WR_ADDR: r_state <= WR_LAT;
            WR_LAT: begin
               r_mem_din  <= bus.sd_buff_din;
               r_mem_wr   <= !r_oor;
               r_mem_addr <= {r_drv, r_lba, r_cnt};
               r_state    <= WR_REQ;
            end
            WR_REQ: begin
               if (r_oor || bus.mem_ready) begin
                  r_mem_wr <= 1'b0;
                  if (w_last) begin
                     r_ack   <= 1'b0;
                     r_state <= DONE;
                  end else begin
                     r_cnt       <= w_cnt_nx;
                     r_buff_addr <= w_cnt_nx;
                     r_state     <= WR_ADDR;
                  end
               end
            end
            DONE: r_state <= IDLE;
         endcase
      end
   end

   assign bus.sd_ack       = r_ack;
   assign bus.sd_buff_addr = r_buff_addr;
   assign bus.sd_buff_dout = r_buff_dout;
   assign bus.sd_buff_wr   = r_buff_wr;
   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_rd       = r_mem_rd;
   assign bus.mem_wr       = r_mem_wr;
   assign bus.mem_din      = r_mem_din;
endmodule

// File: tb/tb_sd_sector_server.sv
// Randomized bench for sd_sector_server: byte-array store, initiator
// buffer with 2-cycle read latency, transaction-level expectations.
module tb_sd_sector_server;
   logic clk_sys = 1'b0;
   logic areset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk_sys = ~clk_sys;

   sd_sector_server_if #(.LBA_W(8), .NDRV(3)) bus ();

   sd_sector_server #(.LBA_W(8), .NDRV(3)) dut (
      .clk_sys (clk_sys),
      .areset  (areset),
      .bus     (bus)
   );

   logic [7:0]  mem  [0:524287];
   logic [7:0]  bufm [0:511];
   int          lat_cfg = 0;
   logic        r_rdy = 1'b0;
   int          r_wc = 0;

   logic [8:0]  q_bw_a [$];
   logic [7:0]  q_bw_d [$];
   logic [18:0] q_mr   [$];
   logic [18:0] q_mw_a [$];
   logic [7:0]  q_mw_d [$];
   int          n_rdcyc = 0;
   int          n_both  = 0;
   int          n_stray = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Store: fixed latency when lat_cfg>0, otherwise always ready.
   assign bus.mem_dout  = mem[bus.mem_addr];
   assign bus.mem_ready = (lat_cfg == 0) ? 1'b1 : r_rdy;

   always @(posedge clk_sys) begin
      if ((bus.mem_rd || bus.mem_wr) && bus.mem_ready) begin
         r_rdy <= 1'b0;
         r_wc  <= 0;
      end else if (bus.mem_rd || bus.mem_wr) begin
         if (r_wc >= lat_cfg - 1) r_rdy <= 1'b1;
         else r_wc <= r_wc + 1;
      end else begin
         r_rdy <= 1'b0;
         r_wc  <= 0;
      end
   end

   // Initiator buffer: data follows the address two edges later.
   always @(posedge clk_sys)
      bus.sd_buff_din <= bufm[bus.sd_buff_addr];

   always @(negedge clk_sys) begin
      if (bus.sd_buff_wr === 1'b1) begin
         q_bw_a.push_back(bus.sd_buff_addr);
         q_bw_d.push_back(bus.sd_buff_dout);
         if (bus.sd_ack !== 1'b1) n_stray++;
      end
      if (bus.mem_rd === 1'b1) n_rdcyc++;
      if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) n_both++;
      if (bus.mem_rd === 1'b1 && bus.mem_ready)
         q_mr.push_back(bus.mem_addr);
      if (bus.mem_wr === 1'b1 && bus.mem_ready) begin
         q_mw_a.push_back(bus.mem_addr);
         q_mw_d.push_back(bus.mem_din);
         mem[bus.mem_addr] = bus.mem_din;
      end
   end

   task automatic clear_q();
      q_bw_a.delete(); q_bw_d.delete(); q_mr.delete();
      q_mw_a.delete(); q_mw_d.delete();
      n_rdcyc = 0;
   endtask

   // Serve every pending drive, lowest index first; the initiator
   // drops a drive's request lines once it sees sd_ack.
   task automatic serve(input logic [2:0] rd, input logic [2:0] wr,
                        input logic [31:0] lba, input int lat);
      logic [2:0] prd, pwr;
      int  d, c, nbad, base;
      bit  isrd, oor;
      lat_cfg    = lat;
      bus.sd_lba = lba;
      bus.sd_rd  = rd;
      bus.sd_wr  = wr;
      prd = rd;
      pwr = wr;
      oor = lba >= 32'd256;
      while ((prd | pwr) != 3'b000) begin
         d = 0;
         while (!(prd[d] | pwr[d])) d++;
         isrd = prd[d];
         base = d * 131072 + int'(lba % 256) * 512;
         c = 0;
         while (bus.sd_ack !== 1'b1 && c < 20) begin
            @(negedge clk_sys); c++;
         end
         chk("ack_rise", bus.sd_ack, 1);
         if (bus.sd_ack !== 1'b1) begin
            bus.sd_rd = '0; bus.sd_wr = '0;
            return;
         end
         clear_q();
         prd[d] = 1'b0;
         pwr[d] = 1'b0;
         bus.sd_rd  = prd;
         bus.sd_wr  = pwr;
         bus.sd_lba = $urandom();
         c = 0;
         while (bus.sd_ack === 1'b1 && c < 512 * (lat + 4) + 50) begin
            @(negedge clk_sys); c++;
         end
         chk("ack_fall", bus.sd_ack, 0);
         bus.sd_lba = lba;
         if (isrd) begin
            chk("rd_nbytes", q_bw_a.size(), 512);
            chk("rd_nmem", q_mr.size(), oor ? 0 : 512);
            nbad = 0;
            for (int i = 0; i < q_bw_a.size(); i++)
               if (q_bw_a[i] != 9'(i) ||
                   q_bw_d[i] != (oor ? 8'h00 : mem[base + i])) nbad++;
            chk("rd_data", nbad, 0);
            nbad = 0;
            for (int i = 0; i < q_mr.size(); i++)
               if (q_mr[i] != 19'(base + i)) nbad++;
            chk("rd_addr", nbad, 0);
            chk("rd_nowr", q_mw_a.size(), 0);
            if (lat > 0 && !oor)
               chk("rd_hold", n_rdcyc >= 512 * (lat + 1), 1);
         end else begin
            chk("wr_nmem", q_mw_a.size(), oor ? 0 : 512);
            nbad = 0;
            for (int i = 0; i < q_mw_a.size(); i++)
               if (q_mw_a[i] != 19'(base + i) || q_mw_d[i] != bufm[i])
                  nbad++;
            chk("wr_data", nbad, 0);
            chk("wr_nobuf", q_bw_a.size(), 0);
            chk("wr_nord", q_mr.size(), 0);
         end
      end
   endtask

   initial begin
      int c, nb;
      logic [2:0] rd, wr;
      logic [31:0] lba;
      for (int a = 0; a < 524288; a++) mem[a] = 8'(a);
      for (int i = 0; i < 512; i++) bufm[i] = 8'h00;
      areset     = 1'b1;
      bus.sd_rd  = '0;
      bus.sd_wr  = '0;
      bus.sd_lba = '0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_ack", bus.sd_ack, 0);
      chk("rst_bwr", bus.sd_buff_wr, 0);
      chk("rst_mrd", bus.mem_rd, 0);
      chk("rst_mwr", bus.mem_wr, 0);
      chk("rst_baddr", bus.sd_buff_addr, 0);
      chk("rst_bdout", bus.sd_buff_dout, 0);
      chk("rst_mdin", bus.mem_din, 0);
      chk("rst_maddr", bus.mem_addr, 0);
      @(negedge clk_sys);
      areset = 1'b0;

      serve(3'b010, 3'b000, 32'd5, 0);
      for (int i = 0; i < 512; i++) bufm[i] = 8'hA5 ^ 8'(i);
      serve(3'b000, 3'b001, 32'h10, 0);
      serve(3'b101, 3'b000, 32'd9, 0);
      serve(3'b001, 3'b000, 32'h100, 0);
      serve(3'b100, 3'b000, 32'd33, 3);

      // Reset partway through a read; request stays up across it.
      lat_cfg    = 0;
      bus.sd_lba = 32'd7;
      bus.sd_rd  = 3'b001;
      c = 0;
      while (bus.sd_ack !== 1'b1 && c < 20) begin
         @(negedge clk_sys); c++;
      end
      clear_q();
      c = 0;
      while (q_bw_a.size() < 100 && c < 2000) begin
         @(negedge clk_sys); c++;
      end
      chk("rst_mid_reach", q_bw_a.size() >= 100, 1);
      areset = 1'b1;
      @(posedge clk_sys);
      #1;
      chk("rst_mid_ack", bus.sd_ack, 0);
      chk("rst_mid_bwr", bus.sd_buff_wr, 0);
      chk("rst_mid_mrd", bus.mem_rd, 0);
      nb = q_bw_a.size();
      repeat (3) @(negedge clk_sys);
      chk("rst_mid_quiet", q_bw_a.size(), nb);
      areset = 1'b0;
      serve(3'b001, 3'b000, 32'd7, 0);

      for (int it = 0; it < 5; it++) begin
         rd = 3'($urandom_range(0, 7));
         wr = 3'($urandom_range(0, 7));
         if ((rd | wr) == 3'b000) rd = 3'b001;
         if ($urandom_range(0, 4) == 0) lba = 32'(256 + $urandom_range(0, 100));
         else lba = 32'($urandom_range(0, 255));
         for (int i = 0; i < 512; i++) bufm[i] = 8'($urandom());
         serve(rd, wr, lba, $urandom_range(0, 2));
      end

      chk("rd_wr_excl", n_both, 0);
      chk("bwr_stray", n_stray, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sd_sector_server.md
SD_SECTOR_SERVER -- requirements
Module: sd_sector_server

Interface
REQ-001 SHALL have parameter LBA_W, default 8: sector-index bits per drive (256 sectors = 128 KiB).
REQ-002 SHALL have parameter NDRV, default 3: number of drive request lines.
REQ-003 SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port areset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port sd_lba  in  32  sector number requested by initiator.
REQ-006 SHALL have port sd_rd  in  NDRV  per-drive read request, level.
REQ-007 SHALL have port sd_wr  in  NDRV  per-drive write request, level.
REQ-008 SHALL have port sd_ack  out  1  high for the whole transfer.
REQ-009 SHALL have port sd_buff_addr  out  9  byte index in the initiator's sector buffer.
REQ-010 SHALL have port sd_buff_dout  out  8  read data to the initiator's buffer.
REQ-011 SHALL have port sd_buff_wr  out  1  one-cycle write strobe for sd_buff_dout at sd_buff_addr.
REQ-012 SHALL have port sd_buff_din  in  8  write data from the initiator's buffer, valid 2 cycles after sd_buff_addr changes.
REQ-013 SHALL have port mem_addr  out  2+LBA_W+9  backing-store byte address = {drive[1:0], lba[LBA_W-1:0], byte[8:0]}.
REQ-014 SHALL have ports mem_rd / mem_wr  out  1 each  backing-store request, held until mem_ready.
REQ-015 SHALL have ports mem_din  out  8  and mem_dout  in  8  backing-store write and read data.
REQ-016 SHALL have port mem_ready  in  1  request completion; mem_dout valid in the same cycle.

Function
REQ-017 SHALL implement states IDLE, ACK, RD_REQ, RD_PUT, WR_ADDR, WR_LAT, WR_REQ, DONE.
REQ-018 IDLE: if (sd_rd|sd_wr)!=0, SHALL select the lowest-index drive with a request (read wins over write on that drive), latch drive and sd_lba, and go to ACK.
REQ-019 ACK: SHALL drive sd_ack=1 from this cycle until DONE, set byte counter to 0, and go to RD_REQ or WR_ADDR.
REQ-020 Request lines changing after latching (the initiator clears them on sd_ack) SHALL NOT affect the transfer in progress.
REQ-021 RD_REQ: SHALL hold mem_rd=1 with mem_addr for the current byte; on mem_ready, SHALL capture mem_dout into sd_buff_dout and go to RD_PUT.
REQ-022 RD_PUT: SHALL pulse sd_buff_wr for exactly 1 cycle with sd_buff_addr = byte counter; if counter=511 go to DONE, else increment and go to RD_REQ.
REQ-023 WR_ADDR: SHALL drive sd_buff_addr = byte counter; WR_LAT SHALL wait 1 cycle; then SHALL sample sd_buff_din into mem_din and enter WR_REQ.
REQ-024 WR_REQ: SHALL hold mem_wr=1 until mem_ready; then, if counter=511, go to DONE, else increment and go to WR_ADDR.
REQ-025 The byte counter SHALL be 9 bits; the 511->0 wrap SHALL never be reached, because DONE is taken at 511.
REQ-026 Out of range (sd_lba >= 2^LBA_W, or drive index > 3): a read SHALL stream 512 bytes of 0x00 without asserting mem_rd; a write SHALL complete without asserting mem_wr.
REQ-027 DONE: SHALL drive sd_ack=0 for 1 cycle, then return to IDLE; a new request SHALL be accepted no earlier than the cycle after DONE.
REQ-028 mem_rd and mem_wr SHALL never be high together; sd_buff_wr SHALL be 0 outside RD_PUT.
REQ-029 Drives with pending requests that were not selected SHALL be served in later transactions, in index order.

Reset
REQ-030 areset SHALL force IDLE and, on the same edge, set sd_ack=0, sd_buff_wr=0, mem_rd=0, mem_wr=0, sd_buff_addr=0, sd_buff_dout=0, mem_din=0, mem_addr=0.
REQ-031 areset asserted mid-transfer SHALL abort the transfer with no further buffer or memory strobes; the partial sector is not restored.
REQ-032 After areset releases, requests still pending SHALL be served normally.

Verification
REQ-033 Scenario: mem preloaded with byte = addr[7:0]; sd_rd=3'b010, sd_lba=5, mem_ready always 1 -> sd_ack high; 512 sd_buff_wr pulses, addr 0..511, data 0x00..0xFF twice; mem_addr {01,0x05,i}; sd_ack falls.
REQ-034 Scenario: sd_wr=3'b001, sd_lba=0x10, buffer holds 0xA5^i -> mem writes at {00,0x10,i} with data 0xA5^i[7:0], each sampled 2 cycles after sd_buff_addr; 512 mem_wr handshakes.
REQ-035 Scenario: sd_rd=3'b101 in one cycle -> drive 0 served first, then drive 2 (mem_addr[18:17]=2'b10).
REQ-036 Scenario: sd_rd=3'b001, sd_lba=0x100 (LBA_W=8) -> 512 bytes of 0x00, mem_rd never asserted, sd_ack still pulses.
REQ-037 Scenario: mem_ready delayed 3 cycles per access -> mem_rd held 3+ cycles per byte, every byte still correct, exactly 512 strobes.
REQ-038 Scenario: areset at byte 100 of a read -> next edge sd_ack=0 with no further sd_buff_wr; with sd_rd still set, the full sector transfer restarts after release.
